window_pool_buffer: RTL
=======================

# window_pool_buffer

Parametrised streaming window buffer for the CNN feature-map path. It accepts a raster-ordered stream of pixels, each carrying CH channels of DW bits. Using K−1 internal line buffers, it emits every K×K window aligned to STRIDE as a single flattened vector for the pooling/convolution stage. Relative to the fixed 34×26, 32-channel, 2×2 buffer, it adds generic geometry, valid/ready backpressure on both sides, a synchronous flush and a frame-done indication.

## Interface
- DW, 32, bits per channel sample
- CH, 32, channels per pixel
- IMG_W, 26, pixels per row (≥ K)
- IMG_H, 34, rows per frame (≥ K)
- K, 2, window edge (2..4)
- STRIDE, 2, window step in both axes (1..K)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the current frame
- in_valid  in  1  in_data holds a pixel
- in_ready  out  1  block can accept a pixel this cycle
- in_data  in  CH*DW  pixel; channel ch at bits [ch*DW +: DW]
- out_valid  out  1  out_win holds a window
- out_ready  in  1  consumer accepts out_win this cycle
- out_win  out  K*K*CH*DW  window; element (r,c,ch) at offset ((r*K+c)*CH+ch)*DW; r=0 is the oldest row, c=0 is the leftmost column
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- A pixel is accepted on a cycle where in_valid && in_ready. in_ready = !(out_valid && !out_ready). in_ready is combinational and has no dependence on in_valid.
- Position counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing per accepted pixel.
  - col wraps to 0 and increments row.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and frame_done pulses on the next cycle.
- Storage:
  - K−1 line buffers of IMG_W×CH×DW hold the previous rows.
  - A K-column shift register per row holds the current window columns.
  - Storage contents are not reset; they are never observable before they are refilled.
- Window trigger: the accepted pixel is at (row, col) with row ≥ K−1, col ≥ K−1, (row−K+1) % STRIDE == 0 and (col−K+1) % STRIDE == 0.
  - Window contents are rows row−K+1..row and cols col−K+1..col.
  - No padding; windows never straddle row or frame boundaries.
- Windows per frame = ((IMG_W−K)/STRIDE+1)·((IMG_H−K)/STRIDE+1), integer division. The default is 13·17 = 221.
- Output stage is a single register. It is loaded with the window and out_valid is set; it clears on out_valid && out_ready unless a new window loads in the same cycle.
- Simultaneous drain and trigger: when out_ready && out_valid coincide with a triggering accept, the new window loads and out_valid stays 1.
- flush:
  - Clears col, row and out_valid, and suppresses frame_done.
  - Any pixel presented in the flush cycle is dropped; in_ready is forced 0 that cycle.
  - The next accepted pixel is (0,0).
- rst: same effect as flush, applied asynchronously; out_win also clears to 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_win=0, frame_done=0, col=row=0.
- Latency: out_valid rises on the cycle after the triggering pixel is accepted, i.e. 1 clock.
- Throughput: one pixel per clock while out_ready=1; an undrained window stalls input via in_ready=0.
- out_win is stable while out_valid && !out_ready, and changes only on a load.
- Frame boundaries: back-to-back frames need no gap. The first pixel of frame N+1 may be accepted in the cycle frame_done pulses for frame N.
- rst mid-frame: outputs reach their reset values immediately. The first window after release needs a full refill, i.e. the pixel at (K−1, K−1).

## Test plan
- Default parameters, in_data channel ch of pixel (r,x) = {r[7:0], x[7:0], ch[15:0]}, out_ready=1, one full frame:
  - The first window follows pixel index 27, i.e. (1,1).
  - It contains (0,0,ch)=0x0000_00ch, (0,1,ch)=0x0001_00ch, (1,0,ch)=0x0100_00ch, (1,1,ch)=0x0101_00ch.
  - Exactly 221 windows; the last is at (33,25); frame_done pulses once.
- Same frame with out_ready toggled 1-in-3:
  - in_ready drops while a window is pending.
  - No window is lost or duplicated: 221 windows, identical in content and order to scenario 1.
- K=3, STRIDE=1, IMG_W=8, IMG_H=6, DW=8, CH=2:
  - The first window follows pixel index 18, i.e. (2,2).
  - 24 windows total; window rows span 3 consecutive image rows.
- flush asserted after pixel (5,10) of the default frame, then a full frame sent:
  - out_valid=0 the cycle after flush.
  - No frame_done for the aborted frame.
  - The next frame yields 221 correct windows.
- rst pulsed mid-frame (asynchronously, between clock edges):
  - out_valid, out_win and frame_done go to 0 immediately.
  - The subsequent frame is correct from (0,0).
- Two back-to-back default frames with no idle cycles: 442 windows; frame_done pulses exactly twice, 884 accepted pixels apart.

Source files
------------

// File: rtl/window_pool_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_pool_buffer
// Description : Streaming K x K window buffer for raster-ordered pixels.
//               K-1 line buffers keep the previous image rows and a small
//               per-row column shift register keeps the K-1 most recent
//               columns. Every window whose top-left corner sits on the
//               STRIDE grid is presented as one flattened vector, with
//               valid/ready on both sides, synchronous flush and a
//               frame-done pulse.
// Ports       : clk, rst (async, active high), flush (sync frame abort)
//               in_valid / in_ready / in_data  : pixel input stream
//               out_valid / out_ready / out_win : window output stream
//               frame_done : one-cycle pulse after a frame's last pixel
// Revision    : 1.0 - initial release
// ============================================================================
module window_pool_buffer #(
  parameter int DW     = 32,
  parameter int CH     = 32,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 34,
  parameter int K      = 2,
  parameter int STRIDE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DW-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*K*CH*DW-1:0]   out_win,
  output logic                   frame_done
);

  localparam int c_PW = CH * DW;
  localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);

  logic [c_CW-1:0]   r_col;
  logic [c_RW-1:0]   r_row;
  logic              w_acc;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_trig;
  int                w_col_off;
  int                w_row_off;

  // r_lb[0] holds the row just above the current one, r_lb[K-2] the oldest.
  logic [c_PW-1:0]   r_lb [K-1][IMG_W];
  // r_sr[r][0] is the leftmost stored column of window row r.
  logic [c_PW-1:0]   r_sr [K][K-1];
  // Window as it looks including the pixel being accepted this cycle.
  logic [c_PW-1:0]   w_el [K][K];
  logic [K*K*c_PW-1:0] w_win;

  // A pending, undrained window blocks input; flush blocks it as well so
  // the pixel presented during the flush cycle is dropped.
  assign in_ready   = !flush && !(out_valid && !out_ready);
  assign w_acc      = in_valid && in_ready;
  assign w_col_last = (r_col == c_COL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);

  // The accepted pixel is the bottom-right corner of a window when both
  // offsets from the first full window position land on the stride grid.
  always_comb begin
    w_col_off = int'(r_col) - (K - 1);
    w_row_off = int'(r_row) - (K - 1);
    w_trig    = (w_col_off >= 0) && (w_row_off >= 0) &&
                ((w_col_off % STRIDE) == 0) && ((w_row_off % STRIDE) == 0);
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      if (c == K - 1) begin : g_new
        // Newest column: old rows come from the line buffers at this
        // column, the bottom row is the incoming pixel itself.
        if (r == K - 1) begin : g_in
          assign w_el[r][c] = in_data;
        end else begin : g_lb
          assign w_el[r][c] = r_lb[K-2-r][r_col];
        end
      end else begin : g_old
        assign w_el[r][c] = r_sr[r][c];
      end
      assign w_win[(r*K+c)*c_PW +: c_PW] = w_el[r][c];
    end
  end

  // Pixel storage is never reset: every location is rewritten before any
  // window can depend on it.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_sr[r][c] <= w_el[r][c+1];
        end
      end
      r_lb[0][r_col] <= in_data;
      for (int j = 1; j < K - 1; j++) begin
        r_lb[j][r_col] <= r_lb[j-1][r_col];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      out_win    <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_acc && w_col_last && w_row_last;
      if (w_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // A new window takes priority over a drain in the same cycle.
      if (w_acc && w_trig) begin
        out_win   <= w_win;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
